l1_loader: RTL and testbench
============================

# l1_loader

Builds the L1 signalling bus consumed by the parameter decoder (num_t2_frames, plp_id, k_bch, etc.). L1 bytes arrive as a framed byte stream. They are assembled into a shadow register bank. A complete block is copied to the live bus only on a frame-boundary commit strobe, so downstream field decoding never sees a half-written L1 set.

## Interface
- L1_LEN_BYTES, default `L1_LEN_BYTES (defines.v): bytes per L1 block; must be ≥ 2.
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DATA_IN  in  8  L1 byte.
- ENA_IN  in  1  DATA_IN valid this cycle.
- START_IN  in  1  qualifies DATA_IN as byte 0 of a block; ignored unless ENA_IN = 1.
- COMMIT_IN  in  1  frame-boundary strobe, single cycle.
- L1_BUS_OUT  out  8*L1_LEN_BYTES  live L1 bus; byte i at bits [8i+7:8i], byte 0 = first received.
- L1_VALID  out  1  live bus loaded at least once since reset.
- BUSY  out  1  state is FILL.
- PENDING  out  1  state is READY (complete block waiting for commit).
- LOAD_DONE  out  1  one-cycle pulse, live bus updated this cycle.
- ERR_SHORT  out  1  one-cycle pulse, block restarted before completion.
- ERR_LONG  out  1  one-cycle pulse, extra byte after a complete block.

## Operation
- Shadow bank: L1_LEN_BYTES × 8 registers. Byte counter CNT, width clog2(L1_LEN_BYTES). Live bank: L1_LEN_BYTES × 8 registers driving L1_BUS_OUT.
- IDLE:
  - ENA&START: shadow[0] ← DATA_IN, CNT ← 1, go to FILL.
  - ENA without START: ignored.
- FILL:
  - ENA&!START: shadow[CNT] ← DATA_IN, CNT++. If CNT was L1_LEN_BYTES-1, go to READY and CNT ← 0.
  - ENA&START: ERR_SHORT pulse, shadow[0] ← DATA_IN, CNT ← 1, stay in FILL.
- READY:
  - COMMIT_IN: live ← shadow, L1_VALID ← 1, LOAD_DONE pulse, go to IDLE.
  - ENA&!START with no COMMIT: ERR_LONG pulse, go to DISCARD. Pending block is lost.
  - ENA&START with no COMMIT: pending block is silently replaced. shadow[0] ← DATA_IN, CNT ← 1, go to FILL.
  - COMMIT together with ENA&START: the commit copies the old shadow contents (pre-edge values), byte 0 of the new block is written, go to FILL. No error.
  - COMMIT together with ENA&!START: commit happens, ERR_LONG pulse, go to DISCARD.
- DISCARD: ENA&START behaves as in IDLE. Everything else is ignored.
- COMMIT_IN in IDLE, FILL or DISCARD: no effect. Live bus and L1_VALID are unchanged.
- The live bus only ever changes as a whole block, never byte by byte.

## Timing
- Reset values: all registers 0, state IDLE. L1_BUS_OUT = 0, all flags and pulses 0.
- All outputs are registered.
- A byte sampled at edge N is in the shadow after edge N.
- The last byte at edge N makes PENDING = 1 after edge N. The earliest effective COMMIT_IN is therefore sampled at edge N+1.
- A COMMIT_IN coinciding with the last byte (edge N) is ignored.
- A COMMIT_IN sampled at edge M puts the new L1_BUS_OUT and LOAD_DONE = 1 in cycle M+1. Latency is one cycle.
- ERR_SHORT and ERR_LONG are high for the single cycle after the offending byte's edge.
- RST asserted mid-FILL: the partial block is dropped and the live bus clears to 0. Downstream must gate on L1_VALID.
- Back-to-back bytes with ENA_IN high every cycle are supported. No stall or backpressure.

## Structure
- defines.v: L1_LEN_BYTES, plus state encodings as localparam-style macros L1LD_IDLE/FILL/READY/DISCARD, 2 bits.
- One natural sub-module: l1_byte_bank. It is a parameterised N×8 register bank with a byte write port (WE, ADDR, DATA), a flat-bus read, and an async clear. It is instantiated twice, for shadow and live; the live bank is written by a full-width load.
- FSM, counter and pulse generation stay in l1_loader.

## Test plan
- Nominal load: stream bytes 0x00..0x3F (L1_LEN_BYTES = 64), then COMMIT one cycle later -> LOAD_DONE pulse, L1_BUS_OUT[7:0] = 0x00, [511:504] = 0x3F, L1_VALID = 1.
- Commit gating: COMMIT pulses during FILL and in the same cycle as the last byte -> L1_BUS_OUT unchanged. A later COMMIT in READY -> update.
- Short block: START at byte 10, then a full 64-byte block of 0xA5 and COMMIT -> ERR_SHORT pulse once, bus = all 0xA5.
- Long block: 65 bytes without COMMIT -> ERR_LONG pulse. Later bytes are ignored until START. Live bus keeps its previous value.
- Simultaneous events: COMMIT together with the START of the next block -> live = previous block, new block fills correctly and commits next frame.
- Reset mid-FILL after 30 bytes -> all outputs 0 next cycle. A fresh full block then loads normally.

Source files
------------

// File: rtl/l1_loader_pkg.sv
// rtl/l1_loader_pkg.sv - shared constants and state encoding for the L1 loader
//
// Purpose: default L1 block length and the loader FSM state type.
// Ports:   none (package).

package l1_loader_pkg;

  // Bytes per L1 signalling block when the instantiating code does not override it.
  localparam int L1_LEN_BYTES_DEF = 64;

  typedef enum logic [1:0] {
    L1LD_IDLE    = 2'd0,
    L1LD_FILL    = 2'd1,
    L1LD_READY   = 2'd2,
    L1LD_DISCARD = 2'd3
  } l1ld_state_t;

endpackage

// File: rtl/l1_byte_bank.sv
// rtl/l1_byte_bank.sv - N x 8 register bank with byte write, full load and flat read
//
// Purpose: storage for one L1 block. Used once as the shadow bank (byte writes)
//          and once as the live bank (full-width load).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high clear of every byte
//   we         byte write enable
//   addr       byte index for the write
//   wdata      byte to write
//   load       full-width load enable, takes priority over we
//   load_data  flat block to load, byte i at [8i+7:8i]
//   bus        flat read of the whole bank, byte i at [8i+7:8i]

module l1_byte_bank #(
  parameter int N  = 64,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [7:0]      wdata,
  input  logic            load,
  input  logic [8*N-1:0]  load_data,
  output logic [8*N-1:0]  bus
);

  logic [7:0] mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'h00;
    end else if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= load_data[8*i +: 8];
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign bus[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/l1_loader.sv
// rtl/l1_loader.sv - assembles framed L1 bytes and publishes whole blocks on commit
//
// Purpose: bytes are collected into a shadow bank; a complete block is copied to
//          the live bus only on a frame-boundary commit, so downstream decoding
//          never observes a partially written L1 set.
// Ports:
//   CLK, RST     clock and asynchronous active-high reset
//   DATA_IN      L1 byte, valid when ENA_IN
//   ENA_IN       byte valid strobe
//   START_IN     marks DATA_IN as byte 0 of a block (only with ENA_IN)
//   COMMIT_IN    frame-boundary commit strobe
//   L1_BUS_OUT   live L1 bus, byte 0 = first received byte at [7:0]
//   L1_VALID     live bus loaded at least once since reset
//   BUSY         block being filled
//   PENDING      complete block waiting for commit
//   LOAD_DONE    pulse, live bus updated this cycle
//   ERR_SHORT    pulse, block restarted before it completed
//   ERR_LONG     pulse, extra byte after a complete block

module l1_loader
  import l1_loader_pkg::*;
#(
  parameter int L1_LEN_BYTES = L1_LEN_BYTES_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                DATA_IN,
  input  logic                      ENA_IN,
  input  logic                      START_IN,
  input  logic                      COMMIT_IN,
  output logic [8*L1_LEN_BYTES-1:0] L1_BUS_OUT,
  output logic                      L1_VALID,
  output logic                      BUSY,
  output logic                      PENDING,
  output logic                      LOAD_DONE,
  output logic                      ERR_SHORT,
  output logic                      ERR_LONG
);

  localparam int CW = (L1_LEN_BYTES > 1) ? $clog2(L1_LEN_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(L1_LEN_BYTES - 1);

  l1ld_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          sh_we;
  logic [CW-1:0] sh_addr;
  logic          live_load;
  logic          err_short_n, err_long_n;
  logic [8*L1_LEN_BYTES-1:0] shadow_bus;

  // Shadow bank: filled byte by byte as the block arrives.
  l1_byte_bank #(.N(L1_LEN_BYTES), .AW(CW)) u_shadow (
    .clk       (CLK),
    .rst       (RST),
    .we        (sh_we),
    .addr      (sh_addr),
    .wdata     (DATA_IN),
    .load      (1'b0),
    .load_data ('0),
    .bus       (shadow_bus)
  );

  // Live bank: only ever loaded as a whole block. Because the load samples the
  // shadow's pre-edge contents, a commit coinciding with a new byte 0 publishes
  // the old block intact.
  l1_byte_bank #(.N(L1_LEN_BYTES), .AW(CW)) u_live (
    .clk       (CLK),
    .rst       (RST),
    .we        (1'b0),
    .addr      ('0),
    .wdata     (8'h00),
    .load      (live_load),
    .load_data (shadow_bus),
    .bus       (L1_BUS_OUT)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= L1LD_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_we       = 1'b0;
    sh_addr     = cnt;
    live_load   = 1'b0;
    err_short_n = 1'b0;
    err_long_n  = 1'b0;

    case (state)
      L1LD_FILL: begin
        if (ENA_IN) begin
          sh_we = 1'b1;
          if (START_IN) begin
            err_short_n = 1'b1;
            sh_addr     = '0;
            cnt_n       = CW'(1);
          end else if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = L1LD_READY;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      L1LD_READY: begin
        live_load = COMMIT_IN;
        if (ENA_IN && START_IN) begin
          // Replaces the pending block (after committing it if COMMIT_IN is set).
          sh_we   = 1'b1;
          sh_addr = '0;
          cnt_n   = CW'(1);
          state_n = L1LD_FILL;
        end else if (ENA_IN) begin
          err_long_n = 1'b1;
          state_n    = L1LD_DISCARD;
        end else if (COMMIT_IN) begin
          state_n = L1LD_IDLE;
        end
      end

      default: begin  // IDLE and DISCARD: wait for a start byte
        if (ENA_IN && START_IN) begin
          sh_we   = 1'b1;
          sh_addr = '0;
          cnt_n   = CW'(1);
          state_n = L1LD_FILL;
        end
      end
    endcase
  end

  // Flags are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      L1_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      PENDING   <= 1'b0;
      LOAD_DONE <= 1'b0;
      ERR_SHORT <= 1'b0;
      ERR_LONG  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      L1_VALID  <= L1_VALID | live_load;
      BUSY      <= (state_n == L1LD_FILL);
      PENDING   <= (state_n == L1LD_READY);
      LOAD_DONE <= live_load;
      ERR_SHORT <= err_short_n;
      ERR_LONG  <= err_long_n;
    end
  end

endmodule

// File: tb/tb_l1_loader.sv
// tb/tb_l1_loader.sv - self-checking bench for l1_loader against a block-level model

module tb_l1_loader;

  localparam int L = 64;
  localparam int W = 8 * L;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   DATA_IN = 8'h00;
  logic         ENA_IN = 1'b0;
  logic         START_IN = 1'b0;
  logic         COMMIT_IN = 1'b0;
  logic [W-1:0] L1_BUS_OUT;
  logic         L1_VALID, BUSY, PENDING, LOAD_DONE, ERR_SHORT, ERR_LONG;

  l1_loader #(.L1_LEN_BYTES(L)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .ENA_IN     (ENA_IN),
    .START_IN   (START_IN),
    .COMMIT_IN  (COMMIT_IN),
    .L1_BUS_OUT (L1_BUS_OUT),
    .L1_VALID   (L1_VALID),
    .BUSY       (BUSY),
    .PENDING    (PENDING),
    .LOAD_DONE  (LOAD_DONE),
    .ERR_SHORT  (ERR_SHORT),
    .ERR_LONG   (ERR_LONG)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err_short = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a block is either being collected, complete and waiting, or
  // absent. Discarding after an overlong block looks the same as having no block.
  logic [7:0]   m_blk[$];
  bit           m_fill, m_pend, m_valid, m_ld, m_es, m_el;
  logic [W-1:0] m_pendv, m_live;

  task automatic model_reset();
    m_blk = {};
    m_fill = 0; m_pend = 0; m_valid = 0;
    m_ld = 0; m_es = 0; m_el = 0;
    m_pendv = '0; m_live = '0;
  endtask

  task automatic model_step(input bit ena, input bit start, input logic [7:0] d, input bit commit);
    m_ld = 0; m_es = 0; m_el = 0;
    if (m_pend) begin
      if (commit) begin
        m_live = m_pendv; m_valid = 1; m_ld = 1;
      end
      if (ena && start) begin
        m_pend = 0; m_blk = {d}; m_fill = 1;
      end else if (ena) begin
        m_pend = 0; m_el = 1;
      end else if (commit) begin
        m_pend = 0;
      end
    end else if (m_fill) begin
      if (ena) begin
        if (start) begin
          m_es = 1; m_blk = {d};
        end else begin
          m_blk.push_back(d);
          if (m_blk.size() == L) begin
            for (int i = 0; i < L; i++) m_pendv[8*i +: 8] = m_blk[i];
            m_pend = 1; m_fill = 0; m_blk = {};
          end
        end
      end
    end else if (ena && start) begin
      m_blk = {d}; m_fill = 1;
    end
  endtask

  task automatic compare_all();
    check("bus",       L1_BUS_OUT, m_live);
    check("valid",     L1_VALID,   m_valid);
    check("busy",      BUSY,       m_fill);
    check("pending",   PENDING,    m_pend);
    check("load_done", LOAD_DONE,  m_ld);
    check("err_short", ERR_SHORT,  m_es);
    check("err_long",  ERR_LONG,   m_el);
  endtask

  task automatic cyc(input bit ena, input bit start, input logic [7:0] d, input bit commit);
    ENA_IN = ena; START_IN = start; DATA_IN = d; COMMIT_IN = commit;
    @(posedge CLK);
    model_step(ena, start, d, commit);
    #1;
    if (ERR_SHORT) n_err_short++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
  endtask

  // Full block: byte i = base + i*step; optional commit on the last byte.
  task automatic send_block(input logic [7:0] base, input logic [7:0] step, input bit commit_last);
    for (int i = 0; i < L; i++)
      cyc(1, i == 0, base + 8'(i) * step, commit_last && (i == L - 1));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ENA_IN = 0; START_IN = 0; COMMIT_IN = 0; DATA_IN = 8'h00;
    #1;
    model_reset();
    check("rst_bus_async", L1_BUS_OUT, '0);
    @(posedge CLK); #1;
    compare_all();
    RST = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_bus",   L1_BUS_OUT, '0);
    check("reset_valid", L1_VALID, 0);
    check("reset_busy",  BUSY, 0);
    check("reset_pend",  PENDING, 0);
    compare_all();
    RST = 1'b0;

    // Nominal load 0x00..0x3F then commit one cycle later.
    send_block(8'h00, 8'h01, 0);
    check("nom_pending", PENDING, 1);
    cyc(0, 0, 8'h00, 1);
    check("nom_load_done", LOAD_DONE, 1);
    check("nom_byte0", L1_BUS_OUT[7:0], 8'h00);
    check("nom_byte63", L1_BUS_OUT[W-1:W-8], 8'h3F);
    check("nom_valid", L1_VALID, 1);
    idle(2);

    // Commit gating: commit mid-fill and on the last byte are ignored.
    for (int i = 0; i < L; i++) cyc(1, i == 0, 8'h40 + 8'(i), (i == 20) || (i == L - 1));
    check("gate_bus_kept", L1_BUS_OUT[W-1:W-8], 8'h3F);
    idle(1);
    cyc(0, 0, 8'h00, 1);
    check("gate_bus_new", L1_BUS_OUT[7:0], 8'h40);

    // Short block then a full block of 0xA5.
    n_err_short = 0;
    for (int i = 0; i < 10; i++) cyc(1, i == 0, 8'(i), 0);
    send_block(8'hA5, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    check("short_pulses", n_err_short, 1);
    check("short_bus", L1_BUS_OUT, {L{8'hA5}});

    // Long block: 65 bytes, stray bytes and a commit are all ignored.
    for (int i = 0; i <= L; i++) cyc(1, i == 0, 8'h11, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h22, i == 2);
    check("long_bus_kept", L1_BUS_OUT, {L{8'hA5}});

    // Commit coinciding with the start of the next block.
    send_block(8'h80, 8'h01, 0);
    for (int i = 0; i < L; i++) cyc(1, i == 0, 8'hC0 + 8'(i), i == 0);
    check("simul_prev_block", L1_BUS_OUT[7:0], 8'h80);
    cyc(0, 0, 8'h00, 1);
    check("simul_next_block", L1_BUS_OUT[7:0], 8'hC0);

    // Reset after 30 bytes, then a fresh block.
    for (int i = 0; i < 30; i++) cyc(1, i == 0, 8'h55, 0);
    do_reset();
    send_block(8'h03, 8'h05, 0);
    cyc(0, 0, 8'h00, 1);
    check("post_rst_valid", L1_VALID, 1);

    // Randomized traffic.
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int i = 0; i < L; i++) begin
            while ($urandom_range(0, 4) == 0) cyc(0, 0, 8'($urandom), $urandom_range(0, 3) == 0);
            cyc(1, i == 0, 8'($urandom), $urandom_range(0, 7) == 0);
          end
          for (int k = $urandom_range(0, 3); k > 0; k--) cyc(0, 0, 8'h00, $urandom_range(0, 1) == 1);
        end
        1: begin
          send_block(8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
          cyc(1, 1, 8'($urandom), 1);
        end
        2: begin
          for (int i = 0; i < 80; i++)
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, 8'($urandom),
                $urandom_range(0, 5) == 0);
        end
        default: begin
          for (int i = 0; i < $urandom_range(1, L - 1); i++) cyc(1, i == 0, 8'($urandom), 0);
          send_block(8'($urandom), 8'h01, 0);
          for (int i = 0; i < $urandom_range(0, 2); i++) cyc(1, 0, 8'($urandom), 0);
          cyc(0, 0, 8'h00, 1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
